aes_round_sched: RTL and testbench

AES_ROUND_SCHED -- requirements
Module: aes_round_sched

---
 rtl/aes_round_sched.sv | 126 ++++++++++++
 tb/tb_aes_round_sched.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sched.sv
// AES encryption round scheduler: sequences AddRoundKey and round-transform engines over Nr rounds.
// Optional key-length selection (keylen port, Nr = 10/12/14) is enabled by defining AES_KEYLEN_SEL_EN.
module aes_round_sched #(
    parameter int NR_DEFAULT = 10,
    parameter int N_W        = 5
) (
    input  logic           ap_clk,
    input  logic           ap_rst,
`ifdef AES_KEYLEN_SEL_EN
    input  logic [1:0]     keylen,
`endif
    input  logic           ap_start,
    output logic           ap_done,
    output logic           ap_idle,
    output logic           ap_ready,
    output logic           ark_start,
    input  logic           ark_done,
    output logic [N_W-1:0] ark_n,
    output logic           rnd_start,
    input  logic           rnd_done,
    output logic           rnd_last,
    output logic           proto_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARK,
        S_ARK_WAIT,
        S_RND,
        S_RND_WAIT,
        S_FIN
    } state_e;

    state_e         state_q, state_d;
    logic [N_W-1:0] round_q, round_d;
    logic [N_W-1:0] nr_q, nr_d;
    logic           err_q, err_d;
    logic [N_W-1:0] nr_sel;

`ifdef AES_KEYLEN_SEL_EN
    always_comb begin
        case (keylen)
            2'd1:    nr_sel = N_W'(12);
            2'd2:    nr_sel = N_W'(14);
            default: nr_sel = N_W'(10);
        endcase
    end
`else
    assign nr_sel = N_W'(NR_DEFAULT);
`endif

    always_comb begin
        state_d   = state_q;
        round_d   = round_q;
        nr_d      = nr_q;
        err_d     = err_q;
        ap_idle   = 1'b0;
        ap_done   = 1'b0;
        ap_ready  = 1'b0;
        ark_start = 1'b0;
        rnd_start = 1'b0;
        rnd_last  = 1'b0;

        // Completions nobody is waiting for are dropped but remembered.
        if ((ark_done && state_q != S_ARK_WAIT) || (rnd_done && state_q != S_RND_WAIT))
            err_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                ap_idle = 1'b1;
                if (ap_start) begin
                    round_d = '0;
                    nr_d    = nr_sel;
                    state_d = S_ARK;
                end
            end
            S_ARK: begin
                ark_start = 1'b1;
                state_d   = S_ARK_WAIT;
            end
            S_ARK_WAIT: begin
                if (ark_done) begin
                    if (round_q == nr_q) begin
                        state_d = S_FIN;
                    end else begin
                        round_d = round_q + N_W'(1);
                        state_d = S_RND;
                    end
                end
            end
            S_RND: begin
                rnd_start = 1'b1;
                rnd_last  = (round_q == nr_q);
                state_d   = S_RND_WAIT;
            end
            S_RND_WAIT: begin
                if (rnd_done)
                    state_d = S_ARK;
            end
            S_FIN: begin
                ap_done  = 1'b1;
                ap_ready = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ark_n     = round_q;
    assign proto_err = err_q;

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            nr_q    <= N_W'(NR_DEFAULT);
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            nr_q    <= nr_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_aes_round_sched.sv
// Randomized bench for aes_round_sched: a schedule-list model predicts every output each cycle.
module tb_aes_round_sched;
    localparam int N_W    = 5;
    localparam int NR_DEF = 10;

    logic           ap_clk = 1'b0;
    logic           ap_rst, ap_start, ark_done, rnd_done;
    logic           ap_done, ap_idle, ap_ready, ark_start, rnd_start, rnd_last, proto_err;
    logic [N_W-1:0] ark_n;
`ifdef AES_KEYLEN_SEL_EN
    logic [1:0]     keylen;
`endif

    always #5 ap_clk = ~ap_clk;

    aes_round_sched #(.NR_DEFAULT(NR_DEF), .N_W(N_W)) dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
`ifdef AES_KEYLEN_SEL_EN
        .keylen    (keylen),
`endif
        .ap_start  (ap_start),
        .ap_done   (ap_done),
        .ap_idle   (ap_idle),
        .ap_ready  (ap_ready),
        .ark_start (ark_start),
        .ark_done  (ark_done),
        .ark_n     (ark_n),
        .rnd_start (rnd_start),
        .rnd_done  (rnd_done),
        .rnd_last  (rnd_last),
        .proto_err (proto_err)
    );

    typedef enum int {EV_ARK, EV_RND, EV_FIN} ev_kind_e;
    typedef struct {
        ev_kind_e kind;
        int       n;
    } ev_t;

    int  errors = 0, checks = 0, cyc = 0;
    bit  rst_r, start_r, force_ark, force_rnd;
    int  d_fix, ark_cd, rnd_cd;
    logic [1:0] kl_r;

    // Model: remaining schedule for the current request, plus whether the head is being issued now.
    ev_t m_q[$];
    bit  m_known, m_active, m_issue, m_err;
    int  m_round, m_nr;

    int  n_ark, n_rnd, n_last, n_done, last_arkn, start_cyc, done_cyc;
    bit  track_gap, pend_gap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int nr_for();
`ifdef AES_KEYLEN_SEL_EN
        case (kl_r)
            2'd1:    return 12;
            2'd2:    return 14;
            default: return 10;
        endcase
`else
        return NR_DEF;
`endif
    endfunction

    function automatic void build(input int nr);
        m_q.delete();
        m_q.push_back('{EV_ARK, 0});
        for (int r = 1; r <= nr; r++) begin
            m_q.push_back('{EV_RND, r});
            m_q.push_back('{EV_ARK, r});
        end
        m_q.push_back('{EV_FIN, nr});
    endfunction

    function automatic int pick_d();
        return (d_fix > 0) ? d_fix : int'($urandom_range(1, 4));
    endfunction

    task automatic clear_obs();
        n_ark = 0; n_rnd = 0; n_last = 0; n_done = 0;
        last_arkn = -1; start_cyc = -1; done_cyc = -1; pend_gap = 0;
    endtask

    // One clock cycle: drive inputs, compare at negedge, advance model and engine responders.
    task automatic step();
        bit e_idle, e_ark, e_rnd, e_last, e_done, w_ark, w_rnd;
        logic [N_W+6:0] act_v, exp_v;
        ap_rst   = rst_r;
        ap_start = start_r;
        ark_done = (ark_cd == 1) || force_ark;
        rnd_done = (rnd_cd == 1) || force_rnd;
`ifdef AES_KEYLEN_SEL_EN
        keylen   = kl_r;
`endif
        @(negedge ap_clk);
        e_idle = !m_active;
        e_ark  = m_active && m_issue && m_q[0].kind == EV_ARK;
        e_rnd  = m_active && m_issue && m_q[0].kind == EV_RND;
        e_done = m_active && m_issue && m_q[0].kind == EV_FIN;
        e_last = e_rnd && m_q[0].n == m_nr;
        if (m_known) begin
            act_v = {ap_idle, ap_done, ap_ready, ark_start, rnd_start, rnd_last, proto_err, ark_n};
            exp_v = {e_idle, e_done, e_done, e_ark, e_rnd, e_last, m_err, N_W'(m_round)};
            chk("outputs", 64'(act_v), 64'(exp_v));
        end
        if (ark_start === 1'b1) begin
            n_ark++;
            last_arkn = int'(ark_n);
            if (pend_gap) begin
                chk("done_to_next_ark", 64'(cyc - done_cyc), 64'd2);
                pend_gap = 0;
            end
        end
        if (rnd_start === 1'b1) n_rnd++;
        if (rnd_last === 1'b1) n_last++;
        if (ap_done === 1'b1) begin
            n_done++;
            done_cyc = cyc;
            if (track_gap) pend_gap = 1;
        end

        w_ark = m_active && !m_issue && m_q[0].kind == EV_ARK;
        w_rnd = m_active && !m_issue && m_q[0].kind == EV_RND;
        ark_cd = (ark_cd > 0) ? ark_cd - 1 : 0;
        rnd_cd = (rnd_cd > 0) ? rnd_cd - 1 : 0;
        if (e_ark) ark_cd = pick_d();
        if (e_rnd) rnd_cd = pick_d();
        if (ap_rst) begin
            m_known  = 1;
            m_active = 0;
            m_issue  = 0;
            m_err    = 0;
            m_round  = 0;
            m_q.delete();
        end else begin
            if ((ark_done && !w_ark) || (rnd_done && !w_rnd)) m_err = 1;
            if (!m_active) begin
                if (ap_start) begin
                    m_nr = nr_for();
                    build(m_nr);
                    m_active  = 1;
                    m_issue   = 1;
                    m_round   = 0;
                    start_cyc = cyc;
                end
            end else if (m_issue) begin
                if (m_q[0].kind == EV_FIN) begin
                    void'(m_q.pop_front());
                    m_active = 0;
                end else begin
                    m_issue = 0;
                end
            end else if ((w_ark && ark_done) || (w_rnd && rnd_done)) begin
                void'(m_q.pop_front());
                m_issue = 1;
                m_round = m_q[0].n;
            end
        end
        @(posedge ap_clk);
        #1;
        cyc++;
    endtask

    task automatic run_until_idle(input int limit);
        for (int i = 0; i < limit && m_active; i++) step();
        step();
    endtask

    task automatic do_reset();
        rst_r = 1;
        step();
        rst_r = 0;
        step();
    endtask

    initial begin
        rst_r = 0; start_r = 0; force_ark = 0; force_rnd = 0; kl_r = 2'd0;
        d_fix = 1; ark_cd = 0; rnd_cd = 0; track_gap = 0;
        m_known = 0; m_active = 0; m_issue = 0; m_err = 0; m_round = 0; m_nr = NR_DEF;
        clear_obs();
        @(posedge ap_clk);
        #1;

        rst_r = 1;
        repeat (2) step();
        rst_r = 0;
        step();
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_ark_n", 64'(ark_n), 64'd0);
        chk("rst_err", 64'(proto_err), 64'd0);

        // Nominal run, engines answer after one cycle.
        d_fix = 1;
        clear_obs();
        start_r = 1;
        step();
        start_r = 0;
        run_until_idle(200);
        chk("basic_ark_pulses", 64'(n_ark), 64'd11);
        chk("basic_rnd_pulses", 64'(n_rnd), 64'd10);
        chk("basic_rnd_last", 64'(n_last), 64'd1);
        chk("basic_last_ark_n", 64'(last_arkn), 64'd10);
        chk("basic_done_count", 64'(n_done), 64'd1);
        chk("basic_latency", 64'(done_cyc - start_cyc), 64'd43);

        // Stray completion while idle.
        force_ark = 1;
        repeat (3) step();
        force_ark = 0;
        step();
        chk("stray_err", 64'(proto_err), 64'd1);
        chk("stray_idle", 64'(ap_idle), 64'd1);
        repeat (3) step();
        chk("err_sticky", 64'(proto_err), 64'd1);
        do_reset();
        chk("err_cleared", 64'(proto_err), 64'd0);

        // Abort in the first RND_WAIT cycle of round 5; the late rnd_done must flag an error.
        d_fix = 3;
        start_r = 1;
        step();
        start_r = 0;
        for (int i = 0; i < 500; i++) begin
            if (m_active && !m_issue && m_q[0].kind == EV_RND && m_q[0].n == 5) break;
            step();
        end
        rst_r = 1;
        step();
        rst_r = 0;
        chk("abort_idle", 64'(ap_idle), 64'd1);
        chk("abort_ark_n", 64'(ark_n), 64'd0);
        clear_obs();
        repeat (6) step();
        chk("abort_no_pulses", 64'(n_ark + n_rnd + n_done), 64'd0);
        chk("abort_late_err", 64'(proto_err), 64'd1);
        do_reset();

        // ap_start held: back-to-back schedules, one idle cycle between them.
        d_fix = 0;
        track_gap = 1;
        clear_obs();
        start_r = 1;
        for (int i = 0; i < 600 && n_done < 3; i++) step();
        start_r = 0;
        run_until_idle(200);
        track_gap = 0;
        pend_gap = 0;
        chk("held_runs", 64'(n_done), 64'd3);
        chk("held_ark_pulses", 64'(n_ark), 64'd33);

        // Random traffic with stray completions and occasional resets.
        for (int i = 0; i < 2000; i++) begin
            start_r   = ($urandom_range(0, 9) == 0);
            force_ark = ($urandom_range(0, 59) == 0);
            force_rnd = ($urandom_range(0, 59) == 0);
            rst_r     = ($urandom_range(0, 299) == 0);
            kl_r      = 2'($urandom_range(0, 3));
            step();
        end
        start_r = 0; force_ark = 0; force_rnd = 0; rst_r = 0;
        run_until_idle(300);
        repeat (6) step();
        do_reset();

`ifdef AES_KEYLEN_SEL_EN
        kl_r = 2'd2;
        d_fix = 3;
        clear_obs();
        start_r = 1;
        step();
        start_r = 0;
        kl_r = 2'd0;
        run_until_idle(400);
        chk("k256_ark_pulses", 64'(n_ark), 64'd15);
        chk("k256_rnd_pulses", 64'(n_rnd), 64'd14);
        chk("k256_last_ark_n", 64'(last_arkn), 64'd14);
        chk("k256_latency", 64'(done_cyc - start_cyc), 64'd117);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
